spi_ram_burst: RTL and testbench

- Parametrised single-port RAM behind the SPI slave's 2-bit-opcode command word.
- Adds to the existing RAM:
  - generic width and depth;
  - auto-incrementing read and write pointers for burst transfers;
  - configurable read latency;
  - tx_ready back-pressure with command-error flagging.
- Sits between the SPI slave deserialiser (rx side) and its serialiser (tx side).

---
 rtl/shared_pkg.sv | 16 +
 rtl/spi_ram_rd_pipe.sv | 95 +++++++++
 rtl/spi_ram_burst.sv | 141 ++++++++++++++
 tb/tb_spi_ram_burst.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared types and default sizes for the burst-capable SPI RAM.
// The opcode lives in the top two bits of every command word.
package shared_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } spi_ram_op_e;

    localparam int DEF_MEM_WIDTH = 8;
    localparam int DEF_ADDR_SIZE = 8;
    localparam int DEF_MEM_DEPTH = 256;

endpackage

// File: rtl/spi_ram_rd_pipe.sv
// Read return path: tracks in-flight reads for READ_LATENCY edges, then holds
// dout/tx_valid until the serialiser side accepts the word.
module spi_ram_rd_pipe #(
    parameter int MEM_WIDTH    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_start,
    input  logic [MEM_WIDTH-1:0] ram_data,
    input  logic                 tx_ready,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic                 in_flight
);

    // first_valid_q marks that the RAM output register holds a fresh word
    logic                 first_valid_q;
    logic                 first_valid_d;
    logic                 last_valid;
    logic [MEM_WIDTH-1:0] last_data;

    logic                 tx_valid_q;
    logic                 tx_valid_d;
    logic [MEM_WIDTH-1:0] dout_q;
    logic [MEM_WIDTH-1:0] dout_d;

    always_comb begin
        first_valid_d = rd_start;
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                 second_valid_q;
            logic                 second_valid_d;
            logic [MEM_WIDTH-1:0] second_data_q;
            logic [MEM_WIDTH-1:0] second_data_d;

            always_comb begin
                second_valid_d = first_valid_q;
                second_data_d  = second_data_q;
                if (first_valid_q) begin
                    second_data_d = ram_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    second_valid_q <= 1'b0;
                end else begin
                    second_valid_q <= second_valid_d;
                end
                second_data_q <= second_data_d;
            end

            assign last_valid = second_valid_q;
            assign last_data  = second_data_q;
            assign in_flight  = first_valid_q | second_valid_q;
        end else begin : g_lat1
            assign last_valid = first_valid_q;
            assign last_data  = ram_data;
            assign in_flight  = first_valid_q;
        end
    endgenerate

    // A new word can only arrive while the hold register is empty, because
    // busy blocks any read from being accepted while tx_valid is high.
    always_comb begin
        tx_valid_d = tx_valid_q;
        dout_d     = dout_q;
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (last_valid) begin
            tx_valid_d = 1'b1;
            dout_d     = last_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_valid_q <= 1'b0;
            tx_valid_q    <= 1'b0;
            dout_q        <= '0;
        end else begin
            first_valid_q <= first_valid_d;
            tx_valid_q    <= tx_valid_d;
            dout_q        <= dout_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign dout     = dout_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Single-port RAM behind the SPI slave command word, with auto-incrementing
// burst pointers, a configurable read latency and tx_ready back-pressure.
module spi_ram_burst
    import shared_pkg::*;
#(
    parameter int MEM_WIDTH    = DEF_MEM_WIDTH,
    parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
    parameter int AUTO_INC     = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [MEM_WIDTH+1:0] din,
    input  logic                 tx_ready,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic [ADDR_SIZE-1:0] addr_wr,
    output logic [ADDR_SIZE-1:0] addr_rd,
    output logic                 busy,
    output logic                 cmd_err
);

    localparam int                   MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    spi_ram_op_e          op;
    logic [MEM_WIDTH-1:0] payload;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic                 addr_in_range;

    logic [ADDR_SIZE-1:0] addr_wr_q;
    logic [ADDR_SIZE-1:0] addr_wr_d;
    logic [ADDR_SIZE-1:0] addr_rd_q;
    logic [ADDR_SIZE-1:0] addr_rd_d;
    logic                 cmd_err_q;
    logic                 cmd_err_d;
    logic [MEM_WIDTH-1:0] ram_data_q;
    logic [MEM_WIDTH-1:0] ram_data_d;

    logic                 mem_we;
    logic                 rd_accept;
    logic                 pipe_tx_valid;
    logic                 pipe_in_flight;

    function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + ADDR_SIZE'(1);
    endfunction

    assign op       = spi_ram_op_e'(din[MEM_WIDTH+1:MEM_WIDTH]);
    assign payload  = din[MEM_WIDTH-1:0];
    assign cmd_addr = din[ADDR_SIZE-1:0];
    // Widened by one bit so a full-depth RAM compares cleanly against 2**ADDR_SIZE
    assign addr_in_range = ({1'b0, cmd_addr} < DEPTH_EXT);

    assign busy = pipe_tx_valid | pipe_in_flight;

    always_comb begin
        addr_wr_d = addr_wr_q;
        addr_rd_d = addr_rd_q;
        cmd_err_d = 1'b0;
        mem_we    = 1'b0;
        rd_accept = 1'b0;
        if (rx_valid) begin
            case (op)
                OP_WR_ADDR: begin
                    if (addr_in_range) addr_wr_d = cmd_addr;
                    else               cmd_err_d = 1'b1;
                end
                OP_WR_DATA: begin
                    mem_we = 1'b1;
                    if (AUTO_INC != 0) addr_wr_d = next_ptr(addr_wr_q);
                end
                OP_RD_ADDR: begin
                    if (addr_in_range) addr_rd_d = cmd_addr;
                    else               cmd_err_d = 1'b1;
                end
                OP_RD_DATA: begin
                    if (busy) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        rd_accept = 1'b1;
                        if (AUTO_INC != 0) addr_rd_d = next_ptr(addr_rd_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Same-edge write and read to one address returns the old word
    always_comb begin
        ram_data_d = ram_data_q;
        if (rd_accept) begin
            ram_data_d = mem[addr_rd_q[MEM_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_wr_q[MEM_AW-1:0]] <= payload;
        end
        ram_data_q <= ram_data_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_wr_q <= '0;
            addr_rd_q <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            addr_wr_q <= addr_wr_d;
            addr_rd_q <= addr_rd_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    spi_ram_rd_pipe #(
        .MEM_WIDTH   (MEM_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .rd_start (rd_accept),
        .ram_data (ram_data_q),
        .tx_ready (tx_ready),
        .dout     (dout),
        .tx_valid (pipe_tx_valid),
        .in_flight(pipe_in_flight)
    );

    assign tx_valid = pipe_tx_valid;
    assign addr_wr  = addr_wr_q;
    assign addr_rd  = addr_rd_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench: dut_a is full depth with one-cycle reads, dut_b is 200 deep
// with two-cycle reads; sel_b steers rx_valid to one of them.
module tb_spi_ram_burst;
    import shared_pkg::*;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [9:0] din;
    logic       tx_ready;
    logic       sel_b;
    logic       rx_valid_a;
    logic       rx_valid_b;

    logic [7:0] dout_a, dout_b;
    logic       tx_valid_a, tx_valid_b;
    logic [7:0] addr_wr_a, addr_wr_b;
    logic [7:0] addr_rd_a, addr_rd_b;
    logic       busy_a, busy_b;
    logic       cmd_err_a, cmd_err_b;

    int total;
    int bad;

    assign rx_valid_a = rx_valid & ~sel_b;
    assign rx_valid_b = rx_valid & sel_b;

    spi_ram_burst #(
        .MEM_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1), .READ_LATENCY(1)
    ) dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid_a), .din(din), .tx_ready(tx_ready),
        .dout(dout_a), .tx_valid(tx_valid_a), .addr_wr(addr_wr_a), .addr_rd(addr_rd_a),
        .busy(busy_a), .cmd_err(cmd_err_a)
    );

    spi_ram_burst #(
        .MEM_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(200), .AUTO_INC(1), .READ_LATENCY(2)
    ) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid_b), .din(din), .tx_ready(tx_ready),
        .dout(dout_b), .tx_valid(tx_valid_b), .addr_wr(addr_wr_b), .addr_rd(addr_rd_b),
        .busy(busy_b), .cmd_err(cmd_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one command across one rising edge; returns on the next falling edge.
    task automatic send(input spi_ram_op_e op, input logic [7:0] pl);
        rx_valid = 1'b1;
        din      = {op, pl};
        @(negedge clk);
        rx_valid = 1'b0;
        din      = '0;
        $display("cmd dut=%s op=%s payload=%h", sel_b ? "B" : "A", op.name(), pl);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (dout_a !== 8'h00 || tx_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_a got dout=%h tx_valid=%b busy=%b want 00/0/0", dout_a, tx_valid_a, busy_a);
        end
        total++;
        if (addr_wr_a !== 8'h00 || addr_rd_a !== 8'h00 || cmd_err_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_ptr_a got wr=%h rd=%h err=%b want 00/00/0", addr_wr_a, addr_rd_a, cmd_err_a);
        end
        total++;
        if (tx_valid_b !== 1'b0 || addr_wr_b !== 8'h00 || addr_rd_b !== 8'h00) begin
            bad++;
            $display("FAIL reset_b got tx_valid=%b wr=%h rd=%h want 0/00/00", tx_valid_b, addr_wr_b, addr_rd_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_burst();
        logic [7:0] exp_data [3];
        exp_data = '{8'h11, 8'h22, 8'h33};
        sel_b = 1'b0;
        tx_ready = 1'b1;
        send(OP_WR_ADDR, 8'hFE);
        total++;
        if (addr_wr_a !== 8'hFE || cmd_err_a !== 1'b0) begin
            bad++;
            $display("FAIL burst_wr_addr got wr=%h err=%b want fe/0", addr_wr_a, cmd_err_a);
        end
        send(OP_WR_DATA, 8'h11);
        send(OP_WR_DATA, 8'h22);
        send(OP_WR_DATA, 8'h33);
        total++;
        if (addr_wr_a !== 8'h01) begin
            bad++;
            $display("FAIL burst_wr_wrap got=%h want=01", addr_wr_a);
        end
        send(OP_RD_ADDR, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            send(OP_RD_DATA, 8'h00);
            @(negedge clk);
            total++;
            if (tx_valid_a !== 1'b1 || dout_a !== exp_data[i]) begin
                bad++;
                $display("FAIL burst_rd%0d got tx_valid=%b dout=%h want 1/%h", i, tx_valid_a, dout_a, exp_data[i]);
            end
            @(negedge clk);
        end
        total++;
        if (addr_rd_a !== 8'h01 || tx_valid_a !== 1'b0) begin
            bad++;
            $display("FAIL burst_rd_end got rd=%h tx_valid=%b want 01/0", addr_rd_a, tx_valid_a);
        end
    endtask

    task automatic test_backpressure();
        int err_cnt;
        int stable_bad;
        err_cnt = 0;
        stable_bad = 0;
        sel_b = 1'b0;
        send(OP_RD_ADDR, 8'h00);
        tx_ready = 1'b0;
        send(OP_RD_DATA, 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                rx_valid = 1'b1;
                din      = {OP_RD_DATA, 8'h00};
            end
            @(negedge clk);
            rx_valid = 1'b0;
            din      = '0;
            if (tx_valid_a !== 1'b1 || dout_a !== 8'h33) stable_bad++;
            if (cmd_err_a === 1'b1) err_cnt++;
        end
        total++;
        if (stable_bad != 0) begin
            bad++;
            $display("FAIL bp_hold got %0d unstable cycles want 0 (dout=%h)", stable_bad, dout_a);
        end
        total++;
        if (err_cnt != 1) begin
            bad++;
            $display("FAIL bp_cmd_err got %0d pulses want 1", err_cnt);
        end
        total++;
        if (addr_rd_a !== 8'h01 || busy_a !== 1'b1) begin
            bad++;
            $display("FAIL bp_addr_rd got rd=%h busy=%b want 01/1", addr_rd_a, busy_a);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        total++;
        if (tx_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got tx_valid=%b busy=%b want 0/0", tx_valid_a, busy_a);
        end
    endtask

    task automatic test_latency();
        sel_b = 1'b0;
        tx_ready = 1'b1;
        send(OP_RD_DATA, 8'h00);
        total++;
        if (tx_valid_a !== 1'b0 || busy_a !== 1'b1) begin
            bad++;
            $display("FAIL lat1_edge0 got tx_valid=%b busy=%b want 0/1", tx_valid_a, busy_a);
        end
        @(negedge clk);
        total++;
        if (tx_valid_a !== 1'b1) begin
            bad++;
            $display("FAIL lat1_edge1 got tx_valid=%b want 1", tx_valid_a);
        end
        @(negedge clk);

        sel_b = 1'b1;
        send(OP_WR_ADDR, 8'h05);
        send(OP_WR_DATA, 8'h5C);
        send(OP_RD_ADDR, 8'h05);
        send(OP_RD_DATA, 8'h00);
        total++;
        if (tx_valid_b !== 1'b0) begin
            bad++;
            $display("FAIL lat2_edge0 got tx_valid=%b want 0", tx_valid_b);
        end
        @(negedge clk);
        total++;
        if (tx_valid_b !== 1'b0 || busy_b !== 1'b1) begin
            bad++;
            $display("FAIL lat2_edge1 got tx_valid=%b busy=%b want 0/1", tx_valid_b, busy_b);
        end
        @(negedge clk);
        total++;
        if (tx_valid_b !== 1'b1 || dout_b !== 8'h5C) begin
            bad++;
            $display("FAIL lat2_edge2 got tx_valid=%b dout=%h want 1/5c", tx_valid_b, dout_b);
        end
        @(negedge clk);
        total++;
        if (tx_valid_b !== 1'b0) begin
            bad++;
            $display("FAIL lat2_drop got tx_valid=%b want 0", tx_valid_b);
        end
    endtask

    task automatic test_out_of_range();
        sel_b = 1'b1;
        tx_ready = 1'b1;
        send(OP_WR_ADDR, 8'hC8);
        total++;
        if (cmd_err_b !== 1'b1 || addr_wr_b !== 8'h06) begin
            bad++;
            $display("FAIL oor_wr got err=%b wr=%h want 1/06", cmd_err_b, addr_wr_b);
        end
        @(negedge clk);
        total++;
        if (cmd_err_b !== 1'b0) begin
            bad++;
            $display("FAIL oor_pulse got err=%b want 0", cmd_err_b);
        end
        send(OP_RD_ADDR, 8'hC8);
        total++;
        if (cmd_err_b !== 1'b1 || addr_rd_b !== 8'h06) begin
            bad++;
            $display("FAIL oor_rd got err=%b rd=%h want 1/06", cmd_err_b, addr_rd_b);
        end
        send(OP_WR_ADDR, 8'hC7);
        total++;
        if (cmd_err_b !== 1'b0 || addr_wr_b !== 8'hC7) begin
            bad++;
            $display("FAIL oor_last got err=%b wr=%h want 0/c7", cmd_err_b, addr_wr_b);
        end
        send(OP_WR_DATA, 8'h01);
        send(OP_WR_DATA, 8'h02);
        total++;
        if (addr_wr_b !== 8'h01) begin
            bad++;
            $display("FAIL oor_wr_wrap got=%h want=01", addr_wr_b);
        end
        send(OP_RD_ADDR, 8'hC7);
        send(OP_RD_DATA, 8'h00);
        total++;
        if (addr_rd_b !== 8'h00) begin
            bad++;
            $display("FAIL oor_rd_wrap got=%h want=00", addr_rd_b);
        end
        repeat (2) @(negedge clk);
        total++;
        if (tx_valid_b !== 1'b1 || dout_b !== 8'h01) begin
            bad++;
            $display("FAIL oor_rd_last got tx_valid=%b dout=%h want 1/01", tx_valid_b, dout_b);
        end
        @(negedge clk);
        send(OP_RD_DATA, 8'h00);
        repeat (2) @(negedge clk);
        total++;
        if (tx_valid_b !== 1'b1 || dout_b !== 8'h02) begin
            bad++;
            $display("FAIL oor_rd_zero got tx_valid=%b dout=%h want 1/02", tx_valid_b, dout_b);
        end
        @(negedge clk);
        sel_b = 1'b0;
    endtask

    task automatic test_raw_and_reset();
        int seen;
        seen = 0;
        sel_b = 1'b0;
        tx_ready = 1'b1;
        send(OP_RD_ADDR, 8'h10);
        send(OP_WR_ADDR, 8'h10);
        send(OP_WR_DATA, 8'hA5);
        send(OP_RD_DATA, 8'h00);
        @(negedge clk);
        total++;
        if (tx_valid_a !== 1'b1 || dout_a !== 8'hA5) begin
            bad++;
            $display("FAIL raw got tx_valid=%b dout=%h want 1/a5", tx_valid_a, dout_a);
        end
        @(negedge clk);
        send(OP_RD_ADDR, 8'h10);
        send(OP_RD_DATA, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        if (tx_valid_a === 1'b1) seen++;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (dout_a !== 8'h00 || addr_wr_a !== 8'h00 || addr_rd_a !== 8'h00 || cmd_err_a !== 1'b0) begin
            bad++;
            $display("FAIL rst_traffic got dout=%h wr=%h rd=%h err=%b want 00/00/00/0", dout_a, addr_wr_a, addr_rd_a, cmd_err_a);
        end
        repeat (4) begin
            @(negedge clk);
            if (tx_valid_a === 1'b1 || busy_a === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rst_mid_read got %0d cycles with tx_valid/busy want 0", seen);
        end
        send(OP_RD_ADDR, 8'h10);
        send(OP_RD_DATA, 8'h00);
        @(negedge clk);
        total++;
        if (tx_valid_a !== 1'b1 || dout_a !== 8'hA5) begin
            bad++;
            $display("FAIL rst_mem_kept got tx_valid=%b dout=%h want 1/a5", tx_valid_a, dout_a);
        end
        @(negedge clk);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        din      = '0;
        tx_ready = 1'b1;
        sel_b    = 1'b0;
        test_reset();
        test_burst();
        test_backpressure();
        test_latency();
        test_out_of_range();
        test_raw_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
